// File: rtl/obi_stream_write_dma.sv
// Stream-to-memory write DMA: accepts a (start address, byte length) command,
// buffers 32-bit stream words in a small FIFO and writes them to memory
// through an OBI manager port, tracking outstanding writes and error responses.

package obi_stream_write_dma_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        mgr_obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [0:0]  rid;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

endpackage

module obi_stream_write_dma
    import obi_stream_write_dma_pkg::*;
#(
    parameter int unsigned FifoDepth      = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [0:0]  AidValue       = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [31:0]  cmd_addr_i,
    input  logic [31:0]  cmd_len_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [31:0]  s_data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Byte enable of the final word: only the bytes covered by the length.
    function automatic logic [3:0] last_be(input logic [1:0] len_lsb);
        logic [3:0] be;
        if (len_lsb == 2'd0) be = 4'hF;
        else                 be = (4'h1 << len_lsb) - 4'h1;
        return be;
    endfunction

    // Number of 32-bit words needed for a byte length, without 32-bit overflow.
    function automatic logic [30:0] word_count(input logic [31:0] len);
        logic [32:0] sum;
        sum = {1'b0, len} + 33'd3;
        return sum[32:2];
    endfunction

    state_e           state_q;
    logic [31:0]      addr_q;
    logic [30:0]      words_q;
    logic [3:0]       be_last_q;
    logic [30:0]      accepted_q;
    logic [30:0]      issued_q;
    logic [OutW-1:0]  out_q;
    logic [OutW-1:0]  out_next;
    logic             err_q;

    logic [31:0]      fifo_mem [FifoDepth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             req;
    logic             rsp_fire;
    logic             is_last;
    logic [30:0]      cmd_words;
    logic             unused_ok;

    assign unused_ok  = ^{cmd_addr_i[1:0], mgr_rsp_i.r.rdata, mgr_rsp_i.r.rid};

    assign cmd_words  = word_count(cmd_len_i);
    assign fifo_full  = (cnt_q == CntW'(FifoDepth));
    assign fifo_empty = (cnt_q == '0);

    // Ready is derived from registered occupancy only, so a full FIFO never
    // accepts even if a pop happens in the same cycle.
    assign s_ready_o  = (state_q == RUN) && (accepted_q < words_q) && !fifo_full;
    assign push       = s_valid_i && s_ready_o;
    assign req        = (state_q == RUN) && !fifo_empty && (out_q < OutW'(MaxOutstanding));
    assign pop        = req && mgr_rsp_i.gnt;
    assign rsp_fire   = (state_q == RUN) && mgr_rsp_i.rvalid;
    assign is_last    = (issued_q == (words_q - 31'd1));

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;

    // Outstanding-write count after this cycle's grant and response.
    always_comb begin
        out_next = out_q;
        case ({pop, rsp_fire})
            2'b10:   out_next = out_q + OutW'(1);
            2'b01:   out_next = out_q - OutW'(1);
            default: out_next = out_q;
        endcase
    end

    // OBI request: all address-phase fields are zero whenever req is low.
    always_comb begin
        mgr_req_o = '0;
        if (req) begin
            mgr_req_o.req     = 1'b1;
            mgr_req_o.a.addr  = addr_q;
            mgr_req_o.a.we    = 1'b1;
            mgr_req_o.a.be    = is_last ? be_last_q : 4'hF;
            mgr_req_o.a.wdata = fifo_mem[rd_ptr_q];
            mgr_req_o.a.aid   = AidValue;
        end
    end

    // FIFO storage; holds data only, so it is not reset.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= s_data_i;
    end

    // FIFO pointers and occupancy; pops only on an accepted OBI request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Transfer FSM: command latch, word/grant/response accounting, completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            words_q    <= '0;
            be_last_q  <= '0;
            accepted_q <= '0;
            issued_q   <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q     <= {cmd_addr_i[31:2], 2'b00};
                        words_q    <= cmd_words;
                        be_last_q  <= last_be(cmd_len_i[1:0]);
                        accepted_q <= '0;
                        issued_q   <= '0;
                        out_q      <= '0;
                        err_q      <= 1'b0;
                        state_q    <= (cmd_words == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) accepted_q <= accepted_q + 31'd1;
                    if (pop) begin
                        addr_q   <= addr_q + 32'd4;
                        issued_q <= issued_q + 31'd1;
                    end
                    out_q <= out_next;
                    if (rsp_fire && mgr_rsp_i.r.err) err_q <= 1'b1;
                    // Finish in the same cycle the last response drains.
                    if ((issued_q == words_q) && (out_next == '0)) state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_stream_write_dma.sv
// Bench for obi_stream_write_dma: an OBI memory responder with configurable
// grant probability and response latency, a stream source, and a reference
// model deriving expected writes from address/length arithmetic.

module tb_obi_stream_write_dma;
    import obi_stream_write_dma_pkg::*;

    typedef struct {
        int due;
        bit err;
    } pend_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst;
    mgr_obi_req_t mgr_req;
    mgr_obi_rsp_t mgr_rsp = '0;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic [31:0]  cmd_len;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         busy;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;

    // knobs written by the main sequence
    bit gnt_en  = 1'b1;
    int gnt_pct = 100;
    int v_pct   = 100;
    int lat     = 1;
    int err_at  = -1;
    int src_hi  = 0;
    logic [31:0] src_mem [8192];

    // responder / source state and counters
    int cyc       = 0;
    int src_rd    = 0;
    int rsp_cnt   = 0;
    int grant_cnt = 0;
    int done_cnt  = 0;
    int stab_bad  = 0;
    int over_cnt  = 0;
    int hit2_cnt  = 0;
    bit prev_wait = 1'b0;
    mgr_obi_a_chan_t prev_a;
    pend_t pend[$];
    wr_t   cap[$];

    // per-transfer baselines
    logic [31:0] cur_addr;
    logic [31:0] cur_len;
    int cur_w, cur_eidx;
    int b_cap, b_rsp, b_done, b_stab, b_over, b_hit2, b_src;

    obi_stream_write_dma dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mgr_req_o   (mgr_req),
        .mgr_rsp_i   (mgr_rsp),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // OBI memory responder and stream source, acting between clock edges.
    always @(negedge clk) begin
        if (rst) begin
            mgr_rsp   = '0;
            s_valid   = 1'b0;
            prev_wait = 1'b0;
            pend.delete();
        end else begin
            mgr_rsp.rvalid = 1'b0;
            mgr_rsp.r.err  = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mgr_rsp.rvalid = 1'b1;
                mgr_rsp.r.err  = pend[0].err;
                void'(pend.pop_front());
                rsp_cnt++;
            end
            if (prev_wait && !(mgr_req.req && mgr_req.a == prev_a)) stab_bad++;
            mgr_rsp.gnt = gnt_en && ($urandom_range(0, 99) < gnt_pct);
            if (mgr_req.req && mgr_rsp.gnt) begin
                cap.push_back('{mgr_req.a.addr, mgr_req.a.wdata, mgr_req.a.be});
                pend.push_back('{cyc + lat, (grant_cnt == err_at)});
                grant_cnt++;
            end
            prev_wait = mgr_req.req && !mgr_rsp.gnt;
            prev_a    = mgr_req.a;
            if (pend.size() > 2)  over_cnt++;
            if (pend.size() == 2) hit2_cnt++;
            if (done) done_cnt++;
            if (src_rd < src_hi) begin
                s_valid = ($urandom_range(0, 99) < v_pct);
                s_data  = src_mem[src_rd];
            end else begin
                s_valid = 1'b0;
            end
            if (s_valid && s_ready) src_rd++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] addr, input logic [31:0] len,
                              input int nextra, input bit fixed, input int eidx);
        longint w;
        w        = (longint'(len) + 3) / 4;
        cur_addr = addr;
        cur_len  = len;
        cur_w    = int'(w);
        cur_eidx = eidx;
        b_cap  = cap.size();
        b_rsp  = rsp_cnt;
        b_done = done_cnt;
        b_stab = stab_bad;
        b_over = over_cnt;
        b_hit2 = hit2_cnt;
        b_src  = src_rd;
        err_at = (eidx >= 0) ? grant_cnt + eidx : -1;
        for (int i = 0; i < cur_w + nextra; i++)
            src_mem[b_src + i] = fixed ? (32'hA1 + 32'h11 * i) : $urandom();
        src_hi = b_src + cur_w + nextra;
        step();
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
        chk("err_cleared_on_accept", {63'd0, err}, 64'd0);
        if (cur_w == 0) begin
            chk("len0_done_next", {63'd0, done}, 64'd1);
            chk("len0_no_req", {63'd0, mgr_req.req}, 64'd0);
        end else begin
            chk("busy_in_run", {63'd0, busy}, 64'd1);
        end
    endtask

    task automatic finish_xfer();
        int n;
        int nb;
        logic [31:0] ea;
        logic [3:0]  eb;
        n = 0;
        while (!done && n < 3000) begin
            step();
            n++;
        end
        chk("done_within_budget", {63'd0, done}, 64'd1);
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
        chk("err_at_done", {63'd0, err}, {63'd0, (cur_eidx >= 0 && cur_eidx < cur_w)});
        chk("responses_before_done", 64'(rsp_cnt - b_rsp), 64'(cur_w));
        repeat (3) step();
        chk("done_pulses", 64'(done_cnt - b_done), 64'd1);
        chk("words_accepted", 64'(src_rd - b_src), 64'(cur_w));
        chk("write_count", 64'(cap.size() - b_cap), 64'(cur_w));
        for (int i = 0; i < cur_w; i++) begin
            if (b_cap + i < cap.size()) begin
                nb = int'(cur_len) - 4 * i;
                if (cur_len > 32'h7FFF_FFFF || nb > 4) nb = 4;
                eb = 4'((1 << nb) - 1);
                ea = (cur_addr & 32'hFFFF_FFFC) + 32'(4 * i);
                chk("wr_addr", {32'd0, cap[b_cap + i].addr}, {32'd0, ea});
                chk("wr_data", {32'd0, cap[b_cap + i].data}, {32'd0, src_mem[b_src + i]});
                chk("wr_be", {60'd0, cap[b_cap + i].be}, {60'd0, eb});
            end
        end
        chk("req_stable_while_waiting", 64'(stab_bad - b_stab), 64'd0);
        chk("outstanding_limit", 64'(over_cnt - b_over), 64'd0);
        chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("idle_no_req", {63'd0, mgr_req.req}, 64'd0);
    endtask

    initial begin
        logic [31:0] hold_addr;
        logic [31:0] hold_data;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (3) step();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_req_zero", {63'd0, (mgr_req == '0)}, 64'd1);
        rst = 1'b0;
        repeat (2) step();

        // two full words from an unaligned address, one surplus stream word
        start_xfer(32'h1000_0003, 32'd8, 1, 1'b1, -1);
        finish_xfer();

        // partial last word, surplus word never accepted
        start_xfer(32'h1000_0100, 32'd6, 1, 1'b0, -1);
        finish_xfer();

        // zero-length command
        start_xfer(32'h1000_0200, 32'd0, 1, 1'b0, -1);
        finish_xfer();

        // grant withheld while the FIFO fills
        gnt_en = 1'b0;
        start_xfer(32'h3000_0000, 32'd16, 0, 1'b0, -1);
        repeat (4) step();
        chk("stall_s_ready_low", {63'd0, s_ready}, 64'd0);
        chk("stall_req_high", {63'd0, mgr_req.req}, 64'd1);
        chk("stall_addr", {32'd0, mgr_req.a.addr}, 64'h3000_0000);
        chk("stall_wdata", {32'd0, mgr_req.a.wdata}, {32'd0, src_mem[b_src]});
        chk("stall_be", {60'd0, mgr_req.a.be}, 64'hF);
        hold_addr = mgr_req.a.addr;
        hold_data = mgr_req.a.wdata;
        repeat (5) begin
            step();
            chk("stall_hold_s_ready", {63'd0, s_ready}, 64'd0);
            chk("stall_hold_addr", {32'd0, mgr_req.a.addr}, {32'd0, hold_addr});
            chk("stall_hold_wdata", {32'd0, mgr_req.a.wdata}, {32'd0, hold_data});
        end
        gnt_en = 1'b1;
        finish_xfer();

        // slow responses limit outstanding writes
        lat = 3;
        start_xfer(32'h4000_0010, 32'd16, 0, 1'b0, -1);
        finish_xfer();
        chk("outstanding_reached_two", {63'd0, (hit2_cnt - b_hit2 > 0)}, 64'd1);
        lat = 1;

        // error on the second of three responses, cleared by the next command
        start_xfer(32'h5000_0000, 32'd12, 0, 1'b0, 1);
        finish_xfer();
        start_xfer(32'h5000_0100, 32'd4, 0, 1'b0, -1);
        finish_xfer();

        // address wraps past the top of the 32-bit space
        start_xfer(32'hFFFF_FFF8, 32'd16, 0, 1'b0, -1);
        finish_xfer();

        // randomized transfers
        for (int k = 0; k < 10; k++) begin
            gnt_pct = $urandom_range(30, 100);
            v_pct   = $urandom_range(30, 100);
            lat     = $urandom_range(1, 4);
            start_xfer($urandom(), 32'($urandom_range(0, 40)), $urandom_range(0, 2), 1'b0,
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : -1);
            finish_xfer();
        end
        gnt_pct = 100;
        v_pct   = 100;
        lat     = 1;

        // asynchronous reset in the middle of a transfer
        gnt_en = 1'b0;
        start_xfer(32'h2000_0000, 32'd32, 0, 1'b0, -1);
        repeat (4) step();
        chk("pre_reset_req", {63'd0, mgr_req.req}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req_drop", {63'd0, mgr_req.req}, 64'd0);
        chk("async_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_s_ready", {63'd0, s_ready}, 64'd0);
        step();
        rst    = 1'b0;
        src_hi = src_rd;
        gnt_en = 1'b1;
        step();
        chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("post_rst_err", {63'd0, err}, 64'd0);
        chk("post_rst_done", {63'd0, done}, 64'd0);

        start_xfer(32'h6000_0004, 32'd10, 1, 1'b0, -1);
        finish_xfer();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
